// File: rtl/raster_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : raster_fill_engine
//  Description : Command-driven rectangle fill engine. Accepts position,
//                index, write-mode, pattern, palette and fill commands and
//                generates one framebuffer pixel slot per cycle, honouring
//                framebuffer backpressure, transparent/opaque pattern modes
//                and screen-edge clipping.
//
//  Ports:
//    clk, reset         - clock, synchronous active-high reset
//    cmd_valid/ready    - command handshake (ready only while idle)
//    cmd_op, cmd_data   - opcode (3b) and operand (32b)
//    abort              - cancels an in-progress fill
//    status             - [0] busy, [1] clip (sticky), [4] idle,
//                         [31:16] completed-fill count
//    fb_wr_*            - framebuffer pixel write port (ready-throttled)
//    palette_wr_*       - palette write port (single-cycle pulse)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_fill_engine #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int COLOR_BITS     = 12,
    parameter int PATTERN_BITS   = 32,
    localparam int XW = $clog2(RESOLUTION_X),
    localparam int YW = $clog2(RESOLUTION_Y),
    localparam int IW = $clog2(PALETTE_LENGTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [31:0]           cmd_data,
    input  logic                  abort,
    output logic [31:0]           status,
    output logic [XW-1:0]         fb_wr_x,
    output logic [YW-1:0]         fb_wr_y,
    output logic [IW-1:0]         fb_wr_index,
    output logic                  fb_wr_en,
    input  logic                  fb_wr_ready,
    output logic [IW-1:0]         palette_wr_index,
    output logic [COLOR_BITS-1:0] palette_wr_color,
    output logic                  palette_wr_en
);

    localparam int PW = (PATTERN_BITS > 1) ? $clog2(PATTERN_BITS) : 1;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_fill = 1'b1;

    localparam logic [2:0] c_op_set_pos     = 3'd1;
    localparam logic [2:0] c_op_set_index   = 3'd2;
    localparam logic [2:0] c_op_set_wmode   = 3'd3;
    localparam logic [2:0] c_op_set_pattern = 3'd4;
    localparam logic [2:0] c_op_fill        = 3'd5;
    localparam logic [2:0] c_op_palette     = 3'd6;

    localparam logic [1:0] c_mode_transparent = 2'd1;
    localparam logic [1:0] c_mode_opaque      = 2'd2;

    localparam logic [16:0] c_res_x = 17'(RESOLUTION_X);
    localparam logic [16:0] c_res_y = 17'(RESOLUTION_Y);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]              r_state;
    logic [15:0]             r_x0, r_y0;
    logic [IW-1:0]           r_fg, r_bg;
    logic [1:0]              r_mode;
    logic [PATTERN_BITS-1:0] r_pattern;
    logic [15:0]             r_w, r_h;
    logic [15:0]             r_gi, r_gj;     // slot generator, one ahead of the output
    logic                    r_gen_done;     // generator exhausted: presented slot is the last
    logic                    r_primed;       // output registers hold a live slot
    logic [15:0]             r_count;
    logic                    r_clip;
    logic [XW-1:0]           r_fb_x;
    logic [YW-1:0]           r_fb_y;
    logic [IW-1:0]           r_fb_index;
    logic                    r_fb_en;
    logic [IW-1:0]           r_pal_index;
    logic [COLOR_BITS-1:0]   r_pal_color;
    logic                    r_pal_en;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [0:0]  w_state_next;
    logic        w_accept;
    logic        w_fill_start;
    logic        w_adv;
    logic        w_fill_done;
    logic        w_load;
    logic [16:0] w_x, w_y;
    logic        w_clip;
    logic        w_pat_bit;
    logic        w_we;
    logic [IW-1:0] w_index;
    logic        w_idle;
    logic        w_busy;

    assign w_accept     = cmd_valid && (r_state == c_st_idle);
    assign w_fill_start = w_accept && (cmd_op == c_op_fill) &&
                          (cmd_data[15:0] != 16'd0) && (cmd_data[31:16] != 16'd0);

    // A presented write slot retires on handshake; a suppressed slot retires at once.
    assign w_adv        = r_primed && (!r_fb_en || fb_wr_ready);
    assign w_fill_done  = (r_state == c_st_fill) && w_adv && r_gen_done;
    assign w_load       = (r_state == c_st_fill) && !abort && !r_gen_done &&
                          (!r_primed || w_adv);

    // Slot geometry, 17-bit so coordinates past the screen never wrap back on it.
    assign w_x    = {1'b0, r_x0} + {1'b0, r_gi};
    assign w_y    = {1'b0, r_y0} + {1'b0, r_gj};
    assign w_clip = (w_x >= c_res_x) || (w_y >= c_res_y);

    generate
        if (PATTERN_BITS == 1) begin : g_pat_single
            assign w_pat_bit = r_pattern[0];
        end else begin : g_pat_multi
            assign w_pat_bit = r_pattern[r_gi[PW-1:0]];
        end
    endgenerate

    assign w_we    = !w_clip && ((r_mode != c_mode_transparent) || w_pat_bit);
    assign w_index = ((r_mode == c_mode_opaque) && !w_pat_bit) ? r_bg : r_fg;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_fill_start)          w_state_next = c_st_fill;
            c_st_fill: if (abort || w_fill_done)  w_state_next = c_st_idle;
            default:                              w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_idle = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            c_st_idle: w_idle = 1'b1;
            c_st_fill: w_busy = 1'b1;
            default:   w_idle = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x0        <= '0;
            r_y0        <= '0;
            r_fg        <= '0;
            r_bg        <= '0;
            r_mode      <= '0;
            r_pattern   <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_gi        <= '0;
            r_gj        <= '0;
            r_gen_done  <= 1'b0;
            r_primed    <= 1'b0;
            r_count     <= '0;
            r_clip      <= 1'b0;
            r_fb_x      <= '0;
            r_fb_y      <= '0;
            r_fb_index  <= '0;
            r_fb_en     <= 1'b0;
            r_pal_index <= '0;
            r_pal_color <= '0;
            r_pal_en    <= 1'b0;
        end else begin
            r_pal_en <= 1'b0;

            if (w_accept) begin
                case (cmd_op)
                    c_op_set_pos: begin
                        r_x0   <= cmd_data[15:0];
                        r_y0   <= cmd_data[31:16];
                        r_clip <= 1'b0;
                    end
                    c_op_set_index: begin
                        r_fg <= cmd_data[IW-1:0];
                        r_bg <= cmd_data[16+IW-1:16];
                    end
                    c_op_set_wmode: begin
                        r_mode <= (cmd_data[1:0] == 2'd3) ? 2'd0 : cmd_data[1:0];
                    end
                    c_op_set_pattern: begin
                        r_pattern <= cmd_data[PATTERN_BITS-1:0];
                    end
                    c_op_fill: begin
                        r_w        <= cmd_data[15:0];
                        r_h        <= cmd_data[31:16];
                        r_gi       <= '0;
                        r_gj       <= '0;
                        r_gen_done <= 1'b0;
                        r_primed   <= 1'b0;
                        // Degenerate rectangle: counts as completed without entering FILL.
                        if ((cmd_data[15:0] == 16'd0) || (cmd_data[31:16] == 16'd0)) begin
                            r_count <= r_count + 16'd1;
                        end
                    end
                    c_op_palette: begin
                        r_pal_index <= cmd_data[IW-1:0];
                        r_pal_color <= cmd_data[16+COLOR_BITS-1:16];
                        r_pal_en    <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (r_state == c_st_fill) begin
                if (abort) begin
                    r_fb_en  <= 1'b0;
                    r_primed <= 1'b0;
                end else if (w_load) begin
                    r_fb_x     <= w_x[XW-1:0];
                    r_fb_y     <= w_y[YW-1:0];
                    r_fb_index <= w_index;
                    r_fb_en    <= w_we;
                    r_primed   <= 1'b1;
                    if (w_clip) begin
                        r_clip <= 1'b1;
                    end
                    // Row-major step of the generator.
                    if (r_gi == r_w - 16'd1) begin
                        r_gi <= '0;
                        if (r_gj == r_h - 16'd1) begin
                            r_gen_done <= 1'b1;
                        end else begin
                            r_gj <= r_gj + 16'd1;
                        end
                    end else begin
                        r_gi <= r_gi + 16'd1;
                    end
                end else if (w_adv) begin
                    // Last slot retired: nothing more to present.
                    r_fb_en  <= 1'b0;
                    r_primed <= 1'b0;
                    r_count  <= r_count + 16'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign cmd_ready        = w_idle;
    assign status           = {r_count, 11'd0, w_idle, 2'b00, r_clip, w_busy};
    assign fb_wr_x          = r_fb_x;
    assign fb_wr_y          = r_fb_y;
    assign fb_wr_index      = r_fb_index;
    assign fb_wr_en         = r_fb_en;
    assign palette_wr_index = r_pal_index;
    assign palette_wr_color = r_pal_color;
    assign palette_wr_en    = r_pal_en;

endmodule
`default_nettype wire

// File: doc/raster_fill_engine.md
# raster_fill_engine

Command-driven rectangle fill engine with write modes, pattern fill, clipping and framebuffer backpressure, sitting between the display processor's memory-mapped command path and the framebuffer and palette write ports. It generalises the display processor's position, index, write-mode and pattern registers into a working pixel generator. Each accepted FILL command produces one framebuffer pixel slot per cycle, stalling under `fb_wr_ready` backpressure. Palette writes are issued from the same command stream.

## Interface
Parameters:
- `RESOLUTION_X`, 400: framebuffer width; `XW = $clog2(RESOLUTION_X)`.
- `RESOLUTION_Y`, 300: framebuffer height; `YW = $clog2(RESOLUTION_Y)`.
- `PALETTE_LENGTH`, 256: palette entries; `IW = $clog2(PALETTE_LENGTH)`, at most 16.
- `COLOR_BITS`, 12: palette colour width, at most 16.
- `PATTERN_BITS`, 32: pattern register width; power of two, at most 32.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_op` in 3: opcode.
- `cmd_data` in 32: operand.
- `abort` in 1: cancels an in-progress fill.
- `status` out 32: `[0]` busy, `[1]` clip (sticky), `[4]` idle, `[31:16]` completed-fill count.
- `fb_wr_x` out XW, `fb_wr_y` out YW, `fb_wr_index` out IW, `fb_wr_en` out 1, `fb_wr_ready` in 1: framebuffer write port.
- `palette_wr_index` out IW, `palette_wr_color` out COLOR_BITS, `palette_wr_en` out 1: palette write port.

## Operation
- States: IDLE and FILL. `cmd_ready = (state == IDLE)`.
- Opcodes are accepted in IDLE on `cmd_valid`:
  - 0 NOP.
  - 1 SET_POS: x0 = `data[15:0]`, y0 = `data[31:16]`; stored as 16-bit values and clears the clip flag.
  - 2 SET_INDEX: fg = `data[IW-1:0]`, bg = `data[16+IW-1:16]`.
  - 3 SET_WMODE: mode = `data[1:0]`; value 3 is stored as 0.
  - 4 SET_PATTERN: pattern = `data[PATTERN_BITS-1:0]`.
  - 5 FILL: w = `data[15:0]`, h = `data[31:16]`. If w == 0 or h == 0 the fill completes immediately: count increments and the engine stays in IDLE. Otherwise it enters FILL with column i = 0 and row j = 0.
  - 6 PALETTE: `palette_wr_index` = `data[IW-1:0]`, `palette_wr_color` = `data[16+COLOR_BITS-1:16]`; `palette_wr_en` pulses for exactly one cycle.
  - 7: treated as NOP.
- FILL pixel slot (i, j):
  - Coordinates: x = x0 + i and y = y0 + j, computed in 17 bits with no wrap.
  - Pattern bit: p = pattern[i mod PATTERN_BITS].
  - Mode 0: write fg.
  - Mode 1 (transparent): write fg if p, otherwise no write.
  - Mode 2 (opaque): write fg if p, otherwise bg.
  - Clipping: if x ≥ RESOLUTION_X or y ≥ RESOLUTION_Y, there is no write and the clip flag is set.
  - Suppressed slots (transparent-skip or clipped) still consume one cycle with `fb_wr_en` low.
- Iteration is row-major: i increments; at i == w−1, i resets to 0 and j increments. The last slot is (w−1, h−1).
- Completion: after the last slot advances, the engine returns to IDLE and the count increments, wrapping 0xFFFF→0.
- `abort` in FILL: return to IDLE on the next cycle. Any held pixel is dropped, `fb_wr_en` goes to 0 and the count does not increment. `abort` is ignored in IDLE.
- `reset` has priority over everything, including mid-fill. All registers clear: x0, y0, fg, bg, mode, pattern = 0, count = 0, clip = 0.

## Timing
- Reset values: `status` = 0x00000010, `cmd_ready` = 1, and all fb_* and palette_* outputs = 0.
- All outputs are registered.
- FILL accepted at edge T: first slot is presented after edge T+1.
- Slot advance:
  - A write slot advances on the edge where `fb_wr_en && fb_wr_ready`.
  - While `fb_wr_ready` is low, x, y, index and en are held stable.
  - A suppressed slot advances unconditionally.
- Peak throughput: 1 pixel/cycle. A w×h fill with `fb_wr_ready` tied high takes w·h cycles from first slot to return to IDLE.
- After the last slot's advance edge, `cmd_ready` = 1, `status[0]` = 0, `status[4]` = 1, and the count is updated in the same cycle.
- `status[0]` = 1 exactly while in FILL.
- PALETTE accepted at edge T: the `palette_wr_en` pulse is visible in cycle T+1. Back-to-back PALETTE commands give consecutive pulses.

## Test plan
- Reset, then SET_POS(10,20), SET_INDEX(fg=5), FILL(3,2), `fb_wr_ready` = 1 → writes (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), all index 5. Six consecutive `fb_wr_en` cycles, then `status` = 0x00010010.
- Mode 1, pattern = 0x5, FILL(4,1) at (0,0) → writes only x = 0 and x = 2. Mode 2 with bg = 9 → x = 1 and x = 3 written with index 9.
- SET_POS(398,299), FILL(4,2) → only (398,299) and (399,299) written; 8 cycles; `status[1]` = 1. A following SET_POS clears it.
- FILL(2,1) with `fb_wr_ready` low for 3 cycles on the first pixel → (x0,y0) held for 4 cycles and written once; `cmd_ready` stays low throughout.
- `abort` asserted in the third slot of FILL(10,10) → `fb_wr_en` = 0 and `cmd_ready` = 1 next cycle, count unchanged. `reset` mid-fill gives the same outcome with all registers cleared.
- PALETTE (index 3, colour 0xABC), then FILL(0,5) → a single `palette_wr_en` pulse with 3/0xABC; count +1 with no `fb_wr_en`.
